// File: rtl/adder_bist_pkg.sv
// Shared types and arithmetic helpers for the adder BIST engine.
// Holds the FSM state encoding, directed-vector counts, the PRNG step and the golden adder.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIRECTED,
        S_RANDOM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int N_DIRECTED_ADD = 8;
    localparam int N_DIRECTED_SUB = 2;

    function automatic logic [63:0] xorshift64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // {cout, sum} lands in bits [width:0]; bits above are zero.
    function automatic logic [64:0] golden(input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub, input int width);
        logic [63:0] mask;
        logic [63:0] bb;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        bb   = (sub ? ~b : b) & mask;
        return {1'b0, a & mask} + {1'b0, bb} + {64'd0, (sub | cin)};
    endfunction

endpackage

// File: rtl/bist_exp_fifo.sv
// Expected-result FIFO: holds {sum, cout, idx} for every issued vector until its result returns.
// Power-of-two depth (>=2) so the pointers wrap for free.
module bist_exp_fifo #(
    parameter int DW    = 49,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adder_bist.sv
// Adder/subtractor BIST: directed corner sweep, then xorshift random sweep, with in-order
// result checking against a golden model and a silence timeout while results are owed.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int          WIDTH      = 32,
    parameter int          NUM_RANDOM = 1000,
    parameter int          SUB_EN     = 0,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TIMEOUT    = 1024,
    parameter logic [63:0] SEED       = 64'h9E3779B97F4A7C15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             passed,
    output logic             timeout,
    output logic [15:0]      err_count,
    output logic [31:0]      first_err_idx,
    output logic             op_valid,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_cin,
    output logic             op_sub,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_sum,
    input  logic             res_cout
);
    localparam int          N_DIR    = N_DIRECTED_ADD + ((SUB_EN != 0) ? N_DIRECTED_SUB : 0);
    localparam logic [31:0] LAST_DIR = 32'(N_DIR - 1);
    localparam logic [31:0] LAST_VEC = 32'(N_DIR + NUM_RANDOM - 1);
    localparam int          DW       = WIDTH + 1 + 32;
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [63:0] P64      = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] Q64      = 64'h5555_5555_5555_5555;

    localparam logic [WIDTH-1:0] V_M = '1;
    localparam logic [WIDTH-1:0] V_H = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] V_P = P64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] V_Q = Q64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] V_1 = WIDTH'(1);

    state_t          state;
    logic [31:0]     idx;
    logic [63:0]     sa;
    logic [63:0]     sb;
    logic [TW-1:0]   silence;

    logic [WIDTH:0]  exp_res;
    logic [DW-1:0]   rdata;
    logic            full;
    logic            empty;
    logic [AW:0]     count;
    logic            pop;
    logic            mismatch;
    logic            unexpected;
    logic            fire_timeout;
    logic            launch;

    logic [WIDTH-1:0] rd_sum;
    logic             rd_cout;
    logic [31:0]      rd_idx;

    always_comb begin
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        op_cin   = 1'b0;
        op_sub   = 1'b0;
        if (state == S_DIRECTED) begin
            op_valid = ~full;
            case (idx[3:0])
                4'd1:    begin op_a = V_M; op_b = V_1; end
                4'd2:    begin op_a = V_M; op_cin = 1'b1; end
                4'd3:    begin op_a = V_P; op_b = V_Q; end
                4'd4:    begin op_a = V_P; op_b = V_Q; op_cin = 1'b1; end
                4'd5:    begin op_a = V_M; op_b = V_M; op_cin = 1'b1; end
                4'd6:    begin op_a = V_H; op_b = V_H; end
                4'd7:    begin op_a = V_Q; op_b = V_P; op_cin = 1'b1; end
                4'd8:    begin op_b = V_1; op_sub = 1'b1; op_cin = 1'b1; end
                4'd9:    begin op_a = V_M; op_b = V_M; op_sub = 1'b1; op_cin = 1'b1; end
                default: ;
            endcase
        end else if (state == S_RANDOM) begin
            op_valid = ~full;
            op_a     = sa[WIDTH-1:0];
            op_b     = sb[WIDTH-1:0];
            op_sub   = (SUB_EN != 0) & idx[0];
            op_cin   = op_sub | sa[63];
        end
    end

    assign exp_res = (WIDTH+1)'(golden(64'(op_a), 64'(op_b), op_cin, op_sub, WIDTH));

    assign rd_sum  = rdata[DW-1 -: WIDTH];
    assign rd_cout = rdata[32];
    assign rd_idx  = rdata[31:0];

    assign launch     = start & ~busy;
    assign pop        = busy & res_valid & ~empty;
    assign mismatch   = pop & ((res_sum != rd_sum) | (res_cout != rd_cout));
    assign unexpected = busy & res_valid & empty;
    // Silence only matters once the random sweep or drain is waiting on results.
    assign fire_timeout = ((state == S_RANDOM) || (state == S_DRAIN)) & ~res_valid
                        & (count != '0) & (silence == TW'(TIMEOUT - 1));
    assign passed = done & (err_count == 16'd0) & ~timeout;

    bist_exp_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (launch),
        .push  (op_valid),
        .pop   (pop),
        .wdata ({exp_res[WIDTH-1:0], exp_res[WIDTH], idx}),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
            idx           <= '0;
            sa            <= SEED;
            sb            <= ~SEED;
            silence       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_DIRECTED;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        timeout       <= 1'b0;
                        err_count     <= '0;
                        first_err_idx <= '1;
                        idx           <= '0;
                        sa            <= SEED;
                        sb            <= ~SEED;
                        silence       <= '0;
                    end
                end
                default: begin
                    if ((mismatch | unexpected) && err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                    if (mismatch && first_err_idx == '1)
                        first_err_idx <= rd_idx;
                    if (op_valid) begin
                        idx <= idx + 32'd1;
                        if (state == S_RANDOM) begin
                            sa <= xorshift64(sa);
                            sb <= xorshift64(sb);
                        end
                    end
                    if (res_valid || count == '0) silence <= '0;
                    else if (silence != '1)        silence <= silence + 1'b1;

                    if (fire_timeout) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        case (state)
                            S_DIRECTED: if (op_valid && idx == LAST_DIR) state <= S_RANDOM;
                            S_RANDOM:   if (op_valid && idx == LAST_VEC) state <= S_DRAIN;
                            S_DRAIN: begin
                                if (empty) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: a behavioural adder responder with latency and fault modes, an
// independent reference vector stream, and scenario runs covering the corner behaviours.
module tb_adder_bist;
    localparam int W     = 16;
    localparam int NR    = 100;
    localparam int ND    = 10;
    localparam int NV    = ND + NR;
    localparam int DEPTH = 8;
    localparam int TMO   = 64;
    localparam int DROP_IDX = 50;
    localparam logic [63:0] SEED = 64'h9E3779B97F4A7C15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, passed, timeout;
    logic [15:0]  err_count;
    logic [31:0]  first_err_idx;
    logic         op_valid, op_cin, op_sub;
    logic [W-1:0] op_a, op_b;
    logic         res_valid = 1'b0;
    logic [W-1:0] res_sum = '0;
    logic         res_cout = 1'b0;

    always #5 clk = ~clk;

    adder_bist #(
        .WIDTH(W), .NUM_RANDOM(NR), .SUB_EN(1), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .passed(passed),
        .timeout(timeout), .err_count(err_count), .first_err_idx(first_err_idx),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        int unsigned  idx;
        int unsigned  ready;
    } op_t;

    vec_t tbl [ND];
    vec_t ref_v [NV];
    op_t  pend_q [$];
    op_t  cap_q [$];

    int checks = 0;
    int failures = 0;

    int unsigned cyc = 0;
    int unsigned issued, resp, max_out, last_res, done_cyc, run_base;
    bit          spur_used;
    int unsigned mode_lat = 1;
    bit          mode_brk = 0, mode_drop = 0, mode_spur = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // Returns {cout, sum}. brk models a carry chain cut between bit 7 and bit 8.
    function automatic logic [W:0] add_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub, input bit brk);
        int unsigned bb, cc, lo, hi;
        if (!brk) begin
            if (sub) return 17'(32'(a) + 32'h10000 - 32'(b));
            return 17'(32'(a) + 32'(b) + 32'(cin));
        end
        bb = sub ? 32'(~b) : 32'(b);
        cc = sub ? 1 : 32'(cin);
        lo = (32'(a) & 32'hFF) + (bb & 32'hFF) + cc;
        hi = (32'(a) >> 8) + (bb >> 8);
        return {hi[8:0], lo[7:0]};
    endfunction

    // Responder: behaves like a DUT with mode_lat cycles of latency.
    always @(negedge clk) begin
        op_t h;
        op_t o;
        logic [W:0] r;
        res_valid = 1'b0;
        res_sum   = '0;
        res_cout  = 1'b0;
        if (!rst_n) begin
            pend_q.delete();
        end else if (start && !busy) begin
            pend_q.delete();
            cap_q.delete();
            issued = 0; resp = 0; max_out = 0; last_res = 0; done_cyc = 0;
            spur_used = 0;
            run_base = cyc + 1;
        end else begin
            if (pend_q.size() != 0 && pend_q[0].ready <= cyc) begin
                h = pend_q.pop_front();
                if (!(mode_drop && h.idx == DROP_IDX)) begin
                    if (!mode_brk && h.idx < ND) r = {tbl[h.idx].cout, tbl[h.idx].sum};
                    else                         r = add_ref(h.a, h.b, h.cin, h.sub, mode_brk);
                    res_valid = 1'b1;
                    res_sum   = r[W-1:0];
                    res_cout  = r[W];
                    resp++;
                    last_res = cyc;
                end
            end else if (mode_spur && !spur_used && op_valid && issued == 0) begin
                res_valid = 1'b1;
                res_sum   = 16'h1234;
                spur_used = 1;
            end
            if (op_valid) begin
                o = '{op_a, op_b, op_cin, op_sub, issued, cyc + mode_lat};
                pend_q.push_back(o);
                cap_q.push_back(o);
                issued++;
            end
            if (issued - resp > max_out) max_out = issued - resp;
            if (done && done_cyc == 0) done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_run(input int lat, input bit brk, input bit drp, input bit spr);
        mode_lat = lat; mode_brk = brk; mode_drop = drp; mode_spur = spr;
        pulse_start();
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        @(negedge clk);
        chk("done_reached", done, 1);
        chk("busy_low_at_done", busy, 0);
    endtask

    task automatic check_stream(input string tag);
        int bad;
        chk({tag, "_n_issued"}, cap_q.size(), NV);
        for (int i = 0; i < ND; i++) begin
            if (i < cap_q.size())
                chk($sformatf("%s_dir%0d", tag, i),
                    {cap_q[i].a, cap_q[i].b, cap_q[i].cin, cap_q[i].sub},
                    {tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub});
        end
        bad = 0;
        for (int i = ND; i < NV; i++) begin
            if (i >= cap_q.size()) bad++;
            else if ({cap_q[i].a, cap_q[i].b, cap_q[i].cin, cap_q[i].sub} !==
                     {ref_v[i].a, ref_v[i].b, ref_v[i].cin, ref_v[i].sub}) bad++;
        end
        chk({tag, "_random_bad"}, bad, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_passed"}, passed, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_first"}, first_err_idx, 32'hFFFF_FFFF);
        chk({tag, "_op_valid"}, op_valid, 0);
    endtask

    initial begin
        logic [63:0] sa, sb;
        logic [W:0]  rg, rb;
        int          exp_err, exp_first;

        tbl[0] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[3] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0};
        tbl[4] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[7] = '{16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[8] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0};
        tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b1};

        for (int i = 0; i < ND; i++) ref_v[i] = tbl[i];
        sa = SEED; sb = ~SEED;
        for (int i = ND; i < NV; i++) begin
            ref_v[i].a   = sa[W-1:0];
            ref_v[i].b   = sb[W-1:0];
            ref_v[i].sub = (i % 2) == 1;
            ref_v[i].cin = ref_v[i].sub ? 1'b1 : sa[63];
            rg = add_ref(ref_v[i].a, ref_v[i].b, ref_v[i].cin, ref_v[i].sub, 0);
            ref_v[i].sum = rg[W-1:0]; ref_v[i].cout = rg[W];
            sa = xs64(sa); sb = xs64(sb);
        end
        exp_err = 0; exp_first = -1;
        for (int i = 0; i < NV; i++) begin
            rg = add_ref(ref_v[i].a, ref_v[i].b, ref_v[i].cin, ref_v[i].sub, 0);
            rb = add_ref(ref_v[i].a, ref_v[i].b, ref_v[i].cin, ref_v[i].sub, 1);
            if (rg != rb) begin
                exp_err++;
                if (exp_first < 0) exp_first = i;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Clean run, registered adder.
        do_run(1, 0, 0, 0);
        chk("clean_passed", passed, 1);
        chk("clean_err", err_count, 0);
        chk("clean_first", first_err_idx, 32'hFFFF_FFFF);
        chk("clean_timeout", timeout, 0);
        chk_range("clean_done_latency", int'(done_cyc - run_base), NV, NV + 4);
        check_stream("clean");
        repeat (5) @(negedge clk);
        chk("done_hold", {done, busy, passed, err_count}, {1'b1, 1'b0, 1'b1, 16'd0});

        // Carry chain broken at bit 8.
        do_run(1, 1, 0, 0);
        chk("brk_passed", passed, 0);
        chk("brk_first", first_err_idx, 32'd1);
        chk("brk_first_model", first_err_idx, 32'(exp_first));
        chk("brk_err", err_count, 16'(exp_err));

        // Long latency with a start pulse while busy that must be ignored.
        mode_lat = 20; mode_brk = 0; mode_drop = 0; mode_spur = 0;
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        @(negedge clk);
        chk("lat_done", done, 1);
        chk("lat_passed", passed, 1);
        chk("lat_err", err_count, 0);
        chk("lat_max_outstanding", max_out, DEPTH);
        check_stream("lat");

        // One result dropped: must time out.
        do_run(1, 0, 1, 0);
        chk("drop_timeout", timeout, 1);
        chk("drop_passed", passed, 0);
        chk_range("drop_timeout_delay", int'(done_cyc - last_res), TMO - 1, TMO + 3);

        // Spurious result with nothing outstanding.
        do_run(1, 0, 0, 1);
        chk("spur_err", err_count, 1);
        chk("spur_first", first_err_idx, 32'hFFFF_FFFF);
        chk("spur_passed", passed, 0);
        chk("spur_timeout", timeout, 0);

        // Reset in the middle of the random sweep, then a clean rerun.
        mode_lat = 1; mode_brk = 0; mode_drop = 0; mode_spur = 0;
        pulse_start();
        repeat (40) @(negedge clk);
        chk("midrun_busy", busy, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        do_run(1, 0, 0, 0);
        chk("rerun_passed", passed, 1);
        chk("rerun_err", err_count, 0);
        chk_range("rerun_done_latency", int'(done_cyc - run_base), NV, NV + 4);
        check_stream("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
